// File: rtl/btb_tagged_assoc_pkg.sv
// Shared types and helpers for the tagged set-associative BTB.
//   BTB_OFFSET        : PC bit where the index field starts (compressed ISA, 2-byte granule)
//   btb_conf_t        : 2-bit confidence counter type
//   CONF_ALLOC        : confidence given to a freshly allocated entry
//   btb_upd_action_t  : what an accepted update does to the addressed set
//   sat_inc           : saturating increment of a confidence counter
package btb_tagged_assoc_pkg;

  localparam int unsigned BTB_OFFSET = 1;

  typedef logic [1:0] btb_conf_t;

  localparam btb_conf_t CONF_ALLOC = 2'd2;
  localparam btb_conf_t CONF_MAX   = 2'd3;

  typedef enum logic [1:0] {
    UPD_NONE,     // miss + clear, or no accepted request
    UPD_REFRESH,  // hit, new target, confidence up
    UPD_WEAKEN,   // hit + clear, confidence down / invalidate
    UPD_ALLOC     // miss, allocate a victim way
  } btb_upd_action_t;

  function automatic btb_conf_t sat_inc(input btb_conf_t c);
    return (c == CONF_MAX) ? c : c + 2'd1;
  endfunction

endpackage

// File: rtl/btb_tagged_assoc_victim_sel.sv
// Victim way selection for one BTB set.
//   valid_i  : valid bit of each way in the set
//   rr_ptr_i : round-robin pointer of the set
//   victim_o : way to overwrite (lowest invalid way, else rr_ptr_i)
//   evict_o  : 1 when the chosen way holds a valid entry
module btb_tagged_assoc_victim_sel
  import btb_tagged_assoc_pkg::*;
#(
  parameter int unsigned NR_WAYS = 2,
  parameter int unsigned WAY_W   = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1
) (
  input  logic [NR_WAYS-1:0] valid_i,
  input  logic [WAY_W-1:0]   rr_ptr_i,
  output logic [WAY_W-1:0]   victim_o,
  output logic               evict_o
);

  logic found;

  always_comb begin
    victim_o = rr_ptr_i;
    evict_o  = 1'b1;
    found    = 1'b0;
    for (int unsigned w = 0; w < NR_WAYS; w++) begin
      if (!found && !valid_i[w]) begin
        victim_o = WAY_W'(w);
        evict_o  = 1'b0;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/btb_tagged_assoc.sv
// Tagged, set-associative branch target buffer for the IF stage.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   flush_i         : invalidate all entries (tags/targets kept)
//   debug_mode_i    : freeze state, lookups continue
//   vpc_i           : fetch PC, looked up combinationally
//   upd_valid_i     : update request from execute
//   upd_pc_i        : PC of the resolved control-flow instruction
//   upd_target_i    : resolved target
//   upd_clear_i     : no branch at upd_pc_i, weaken/remove entry
//   pred_valid_o    : vpc_i hits a valid entry
//   pred_target_o   : target of the hitting way, zero on miss
module btb_tagged_assoc
  import btb_tagged_assoc_pkg::*;
#(
  parameter int unsigned VLEN     = 64,
  parameter int unsigned NR_SETS  = 16,
  parameter int unsigned NR_WAYS  = 2,
  parameter int unsigned TAG_BITS = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            debug_mode_i,
  input  logic [VLEN-1:0] vpc_i,
  input  logic            upd_valid_i,
  input  logic [VLEN-1:0] upd_pc_i,
  input  logic [VLEN-1:0] upd_target_i,
  input  logic            upd_clear_i,
  output logic            pred_valid_o,
  output logic [VLEN-1:0] pred_target_o
);

  localparam int unsigned IDX_W = $clog2(NR_SETS);
  localparam int unsigned WAY_W = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;
  localparam int unsigned TAG_LO = IDX_W + BTB_OFFSET;
  localparam int unsigned TAG_HI = IDX_W + TAG_BITS;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [VLEN-1:0]     target;
    btb_conf_t           conf;
  } btb_tagged_entry_t;

  btb_tagged_entry_t btb_q [NR_SETS][NR_WAYS];

  // ---------------- lookup ----------------
  logic [IDX_W-1:0]    lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic                lk_hit;

  assign lk_idx = vpc_i[IDX_W:BTB_OFFSET];
  assign lk_tag = vpc_i[TAG_HI:TAG_LO];

  always_comb begin
    lk_hit        = 1'b0;
    pred_target_o = '0;
    for (int unsigned w = 0; w < NR_WAYS; w++) begin
      if (!lk_hit && btb_q[lk_idx][w].valid && btb_q[lk_idx][w].tag == lk_tag) begin
        lk_hit        = 1'b1;
        pred_target_o = btb_q[lk_idx][w].target;
      end
    end
  end

  assign pred_valid_o = lk_hit;

  // ---------------- update decode ----------------
  logic [IDX_W-1:0]    upd_idx;
  logic [TAG_BITS-1:0] upd_tag;
  logic                upd_en;
  logic                upd_hit;
  logic [WAY_W-1:0]    upd_hit_way;
  logic [NR_WAYS-1:0]  set_valid;
  logic [WAY_W-1:0]    rr_cur;
  logic [WAY_W-1:0]    victim;
  logic                evict;
  btb_upd_action_t     action;

  assign upd_idx = upd_pc_i[IDX_W:BTB_OFFSET];
  assign upd_tag = upd_pc_i[TAG_HI:TAG_LO];
  assign upd_en  = upd_valid_i && !debug_mode_i && !flush_i;

  always_comb begin
    upd_hit     = 1'b0;
    upd_hit_way = '0;
    set_valid   = '0;
    for (int unsigned w = 0; w < NR_WAYS; w++) begin
      set_valid[w] = btb_q[upd_idx][w].valid;
      if (!upd_hit && btb_q[upd_idx][w].valid && btb_q[upd_idx][w].tag == upd_tag) begin
        upd_hit     = 1'b1;
        upd_hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    action = UPD_NONE;
    if (upd_en) begin
      if (upd_hit) action = upd_clear_i ? UPD_WEAKEN : UPD_REFRESH;
      else         action = upd_clear_i ? UPD_NONE   : UPD_ALLOC;
    end
  end

  btb_tagged_assoc_victim_sel #(
    .NR_WAYS (NR_WAYS),
    .WAY_W   (WAY_W)
  ) i_victim_sel (
    .valid_i  (set_valid),
    .rr_ptr_i (rr_cur),
    .victim_o (victim),
    .evict_o  (evict)
  );

  // ---------------- round-robin pointers ----------------
  generate
    if (NR_WAYS > 1) begin : g_rr
      logic [WAY_W-1:0] rr_q [NR_SETS];

      assign rr_cur = rr_q[upd_idx];

      // Pointer only moves when a live entry is displaced; filling an empty
      // way leaves the rotation untouched.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int unsigned s = 0; s < NR_SETS; s++) rr_q[s] <= '0;
        end else if (flush_i) begin
          for (int unsigned s = 0; s < NR_SETS; s++) rr_q[s] <= '0;
        end else if (action == UPD_ALLOC && evict) begin
          rr_q[upd_idx] <= rr_q[upd_idx] + 1'b1;
        end
      end
    end else begin : g_no_rr
      assign rr_cur = '0;
    end
  endgenerate

  // ---------------- storage ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < NR_SETS; s++)
        for (int unsigned w = 0; w < NR_WAYS; w++)
          btb_q[s][w] <= '0;
    end else if (flush_i) begin
      for (int unsigned s = 0; s < NR_SETS; s++)
        for (int unsigned w = 0; w < NR_WAYS; w++) begin
          btb_q[s][w].valid <= 1'b0;
          btb_q[s][w].conf  <= '0;
        end
    end else begin
      case (action)
        UPD_REFRESH: begin
          btb_q[upd_idx][upd_hit_way].target <= upd_target_i;
          btb_q[upd_idx][upd_hit_way].conf   <= sat_inc(btb_q[upd_idx][upd_hit_way].conf);
        end
        UPD_WEAKEN: begin
          if (btb_q[upd_idx][upd_hit_way].conf <= 2'd1) begin
            btb_q[upd_idx][upd_hit_way].valid <= 1'b0;
            btb_q[upd_idx][upd_hit_way].conf  <= '0;
          end else begin
            btb_q[upd_idx][upd_hit_way].conf <= btb_q[upd_idx][upd_hit_way].conf - 2'd1;
          end
        end
        UPD_ALLOC: begin
          btb_q[upd_idx][victim].valid  <= 1'b1;
          btb_q[upd_idx][victim].tag    <= upd_tag;
          btb_q[upd_idx][victim].target <= upd_target_i;
          btb_q[upd_idx][victim].conf   <= CONF_ALLOC;
        end
        default: ;
      endcase
    end
  end

  // PC bits outside the index/tag window do not participate.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{vpc_i[VLEN-1:TAG_HI+1], vpc_i[0],
                            upd_pc_i[VLEN-1:TAG_HI+1], upd_pc_i[0]};

endmodule

// File: tb/tb_btb_tagged_assoc.sv
module tb_btb_tagged_assoc;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        dbg;
  logic [63:0] vpc;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic [63:0] upd_target;
  logic        upd_clear;
  logic        pred_valid;
  logic [63:0] pred_target;

  btb_tagged_assoc #(
    .VLEN     (64),
    .NR_SETS  (16),
    .NR_WAYS  (2),
    .TAG_BITS (8)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .debug_mode_i  (dbg),
    .vpc_i         (vpc),
    .upd_valid_i   (upd_valid),
    .upd_pc_i      (upd_pc),
    .upd_target_i  (upd_target),
    .upd_clear_i   (upd_clear),
    .pred_valid_o  (pred_valid),
    .pred_target_o (pred_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [63:0] t;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  logic  lk_req;
  int    total;
  int    bad;

  // index = pc[4:1], tag = pc[12:5]
  localparam logic [63:0] P  = 64'h8000_0010;  // set 8, tag 0
  localparam logic [63:0] P2 = 64'h8000_0030;  // set 8, tag 1
  localparam logic [63:0] A  = 64'h8000_0006;  // set 3, tag 0
  localparam logic [63:0] B  = 64'h8000_0026;  // set 3, tag 1
  localparam logic [63:0] C  = 64'h8000_0046;  // set 3, tag 2
  localparam logic [63:0] D  = 64'h8000_0066;  // set 3, tag 3
  localparam logic [63:0] E  = 64'h8000_000A;  // set 5
  localparam logic [63:0] F  = 64'h8000_000C;  // set 6
  localparam logic [63:0] G  = 64'h8000_0004;  // set 2

  // Monitor: sample combinational prediction mid-cycle, compare against queue.
  always @(negedge clk) begin
    if (lk_req) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL no_expectation: got v=%0b t=%h, required none queued", pred_valid, pred_target);
      end else begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (pred_valid !== e.v || pred_target !== e.t) begin
          bad++;
          $display("FAIL %s: got v=%0b t=%h, required v=%0b t=%h",
                   nm, pred_valid, pred_target, e.v, e.t);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    upd_clear = 1'b0;
    flush     = 1'b0;
    lk_req    = 1'b0;
  endtask

  task automatic look(input logic [63:0] pc, input logic ev, input logic [63:0] et,
                      input string nm);
    vpc    = pc;
    lk_req = 1'b1;
    exp_q.push_back('{v: ev, t: et});
    name_q.push_back(nm);
  endtask

  task automatic upd(input logic [63:0] pc, input logic [63:0] tgt, input logic clr);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_target = tgt;
    upd_clear  = clr;
  endtask

  task automatic upd_step(input logic [63:0] pc, input logic [63:0] tgt, input logic clr);
    upd(pc, tgt, clr);
    step();
  endtask

  task automatic look_step(input logic [63:0] pc, input logic ev, input logic [63:0] et,
                           input string nm);
    look(pc, ev, et, nm);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; lk_req = 1'b0;
    rst_n = 1'b0; flush = 1'b0; dbg = 1'b0; vpc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // 1 reset state
    look_step(64'h8000_0000, 1'b0, 64'h0, "reset_lookup");

    // 2 basic hit, tag discrimination
    upd_step(P, 64'h8000_0100, 1'b0);
    look_step(P,  1'b1, 64'h8000_0100, "basic_hit");
    look_step(P2, 1'b0, 64'h0, "tag_mismatch_miss");

    // 3 replacement in set 3
    upd_step(A, 64'hA0, 1'b0);
    upd_step(B, 64'hB0, 1'b0);
    look_step(A, 1'b1, 64'hA0, "rr_A_resident");
    look_step(B, 1'b1, 64'hB0, "rr_B_resident");
    upd_step(C, 64'hC0, 1'b0);
    look_step(A, 1'b0, 64'h0,  "rr_A_evicted");
    look_step(B, 1'b1, 64'hB0, "rr_B_kept");
    look_step(C, 1'b1, 64'hC0, "rr_C_hit");
    upd_step(D, 64'hD0, 1'b0);
    look_step(B, 1'b0, 64'h0,  "rr_B_evicted");
    look_step(C, 1'b1, 64'hC0, "rr_C_kept");
    look_step(D, 1'b1, 64'hD0, "rr_D_hit");

    // 4 confidence
    upd_step(E, 64'hE0, 1'b0);          // conf 2
    upd_step(E, 64'h0, 1'b1);           // conf 1
    look_step(E, 1'b1, 64'hE0, "conf_one_clear_hit");
    upd_step(E, 64'h0, 1'b1);           // invalid
    look_step(E, 1'b0, 64'h0, "conf_two_clear_miss");
    upd_step(E, 64'hE1, 1'b0);          // conf 2
    upd_step(E, 64'hE2, 1'b0);          // conf 3
    upd_step(E, 64'hE3, 1'b0);          // conf 3 (sat)
    look_step(E, 1'b1, 64'hE3, "conf_refresh_target");
    upd_step(E, 64'h0, 1'b1);           // 2
    upd_step(E, 64'h0, 1'b1);           // 1
    look_step(E, 1'b1, 64'hE3, "conf_sat_two_clears_hit");
    upd_step(E, 64'h0, 1'b1);           // invalid
    look_step(E, 1'b0, 64'h0, "conf_sat_three_clears_miss");
    upd_step(F, 64'h0, 1'b1);           // miss + clear: nothing
    look_step(F, 1'b0, 64'h0, "miss_clear_no_alloc");

    // 5 flush beats update; debug freezes state
    upd(F, 64'hF0, 1'b0);
    flush = 1'b1;
    step();
    look_step(P, 1'b0, 64'h0, "flush_P_miss");
    look_step(C, 1'b0, 64'h0, "flush_C_miss");
    look_step(F, 1'b0, 64'h0, "flush_drops_update");
    dbg = 1'b1;
    upd_step(F, 64'hF0, 1'b0);
    look_step(F, 1'b0, 64'h0, "debug_no_alloc");
    dbg = 1'b0;

    // 6 same-cycle update/lookup
    upd(P, 64'h1111, 1'b0);
    look_step(P, 1'b0, 64'h0, "same_cycle_old_miss");
    upd(P, 64'h2222, 1'b0);
    look_step(P, 1'b1, 64'h1111, "same_cycle_old_target");
    look_step(P, 1'b1, 64'h2222, "next_cycle_new_target");

    // reset mid-stream
    upd_step(G, 64'h6060, 1'b0);
    look_step(G, 1'b1, 64'h6060, "pre_reset_hit");
    #2 rst_n = 1'b0;
    look(P, 1'b0, 64'h0, "in_reset_miss");
    step();
    rst_n = 1'b1;
    look_step(G, 1'b0, 64'h0, "post_reset_G_miss");
    look_step(P, 1'b0, 64'h0, "post_reset_P_miss");

    repeat (2) step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
